floo_req_chan_sched: RTL and testbench

// Schedules the four FlooReq-class channels (NarrowAw=0, NarrowW=1, NarrowAr=2, WideAr=3, nw_ch_e order)

---
 rtl/floo_req_chan_sched.sv | 124 ++++++++++++
 tb/tb_floo_req_chan_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/floo_req_chan_sched.sv
// Round-robin scheduler of the four FlooReq channels onto one shared link.
// Enforces AW-before-W ordering and locks W bursts until their last beat.
module floo_req_chan_sched #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxOutAw  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [3:0]                       valid_i,
  output logic [3:0]                       ready_o,
  input  logic [3:0]                       last_i,
  input  logic [4*DataWidth-1:0]           data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [DataWidth-1:0]             data_o,
  output logic [1:0]                       chan_o,
  output logic [$clog2(MaxOutAw+1)-1:0]    aw_pend_o,
  output logic                             locked_o
);

  localparam int unsigned AwW = $clog2(MaxOutAw + 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WLOCK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       hold_q, hold_d;
  logic [AwW-1:0]   aw_pend_q, aw_pend_d;

  logic [3:0] elig, req;
  logic [1:0] arb_g, cand, gnt;
  logic       arb_vld, gnt_vld, sel_vld, hs, w_open;
  logic       unused_last;

  // Arbitration, grant selection and next-state logic
  always_comb begin
    elig        = {2'b11, (aw_pend_q != '0), (aw_pend_q < AwW'(MaxOutAw))};
    req         = valid_i & elig;
    arb_g       = 2'd0;
    arb_vld     = 1'b0;
    cand        = 2'd0;
    unused_last = ^{last_i[3:2], last_i[0]};
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!arb_vld && req[cand]) begin
        arb_g   = cand;
        arb_vld = 1'b1;
      end
    end

    case (state_q)
      ST_HOLD: begin
        gnt     = hold_q;
        gnt_vld = valid_i[hold_q];
      end
      ST_WLOCK: begin
        gnt     = 2'd1;
        gnt_vld = valid_i[1];
      end
      default: begin
        gnt     = arb_g;
        gnt_vld = arb_vld;
      end
    endcase

    sel_vld = gnt_vld & ~rst_i;
    hs      = sel_vld & ready_i;
    w_open  = (gnt == 2'd1) & ~last_i[1];

    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    aw_pend_d = aw_pend_q;
    if (hs) begin
      // In WLOCK the grant is ch1, so gnt+1 keeps the pointer at 2
      ptr_d   = gnt + 2'd1;
      state_d = w_open ? ST_WLOCK : ST_ARB;
      if (gnt == 2'd0) begin
        aw_pend_d = aw_pend_q + AwW'(1);
      end else if ((gnt == 2'd1) && last_i[1]) begin
        aw_pend_d = aw_pend_q - AwW'(1);
      end
    end else if ((state_q == ST_ARB) && sel_vld) begin
      state_d = ST_HOLD;
      hold_d  = arb_g;
    end

    valid_o = sel_vld;
    chan_o  = sel_vld ? gnt : 2'd0;
    ready_o = 4'd0;
    data_o  = '0;
    if (sel_vld) begin
      ready_o[gnt] = ready_i;
    end
    for (int i = 0; i < 4; i++) begin
      if (sel_vld && (gnt == 2'(i))) begin
        data_o = data_i[i*DataWidth +: DataWidth];
      end
    end
    aw_pend_o = rst_i ? '0 : aw_pend_q;
    locked_o  = ~rst_i & (state_q == ST_WLOCK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ARB;
      ptr_q     <= 2'd0;
      hold_q    <= 2'd0;
      aw_pend_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      aw_pend_q <= aw_pend_d;
      assert (!(hs && (gnt == 2'd0) && (aw_pend_q == AwW'(MaxOutAw))));
      assert (!(hs && (gnt == 2'd1) && last_i[1] && (aw_pend_q == '0)));
    end
  end

endmodule

// File: tb/tb_floo_req_chan_sched.sv
// Directed table-driven bench for floo_req_chan_sched with hand-computed expectations.
module tb_floo_req_chan_sched;

  localparam int unsigned DataWidth = 64;
  localparam int unsigned MaxOutAw  = 4;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b1;
  logic [3:0]             valid_i = 4'd0;
  logic [3:0]             ready_o;
  logic [3:0]             last_i = 4'hF;
  logic [4*DataWidth-1:0] data_i;
  logic                   valid_o;
  logic                   ready_i = 1'b0;
  logic [DataWidth-1:0]   data_o;
  logic [1:0]             chan_o;
  logic [2:0]             aw_pend_o;
  logic                   locked_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  floo_req_chan_sched #(.DataWidth(DataWidth), .MaxOutAw(MaxOutAw)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .last_i   (last_i),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .data_o   (data_o),
    .chan_o   (chan_o),
    .aw_pend_o(aw_pend_o),
    .locked_o (locked_o)
  );

  function automatic logic [63:0] pay(int ch);
    return {16'hC0DE, 16'(ch), 32'h1234_5678 + 32'(ch)};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) data_i[i*DataWidth +: DataWidth] = pay(i);
  end

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] last;
    logic       rdy;
    logic       ev;
    logic [1:0] ech;
    logic [2:0] eaw;
    logic       elk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rst, logic [3:0] vld, logic [3:0] last, logic rdy,
                             logic ev, logic [1:0] ech, logic [2:0] eaw, logic elk);
    vec_t r;
    r.rst = rst; r.vld = vld; r.last = last; r.rdy = rdy;
    r.ev = ev; r.ech = ech; r.eaw = eaw; r.elk = elk;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [3:0] vld, logic [3:0] last, logic rdy);
    @(posedge clk);
    #1;
    rst_i = rst; valid_i = vld; last_i = last; ready_i = rdy;
  endtask

  task automatic expect_out(string tag, logic ev, logic [1:0] ech, logic [2:0] eaw,
                            logic elk, logic rdy);
    logic [3:0]  er;
    logic [63:0] ed;
    @(negedge clk);
    er = (ev && rdy) ? 4'(1 << ech) : 4'd0;
    ed = ev ? pay(int'(ech)) : 64'd0;
    chk({tag, " valid"},   64'(valid_o),   64'(ev));
    chk({tag, " ready"},   64'(ready_o),   64'(er));
    chk({tag, " chan"},    64'(chan_o),    64'(ech));
    chk({tag, " data"},    data_o,         ed);
    chk({tag, " aw_pend"}, 64'(aw_pend_o), 64'(eaw));
    chk({tag, " locked"},  64'(locked_o),  64'(elk));
  endtask

  initial begin
    // Reset held with all channels requesting, then RR fairness
    repeat (3) vecs.push_back(v(1, 4'hF, 4'hF, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'h0, 4'hF, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'hC, 4'hF, 1, 1, 2, 0, 0));
    vecs.push_back(v(0, 4'hC, 4'hF, 1, 1, 3, 0, 0));
    vecs.push_back(v(0, 4'hC, 4'hF, 1, 1, 2, 0, 0));
    vecs.push_back(v(0, 4'hC, 4'hF, 1, 1, 3, 0, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 2, 1, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 3, 1, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 2, 2, 0));
    vecs.push_back(v(0, 4'hD, 4'hF, 1, 1, 3, 2, 0));
    vecs.push_back(v(1, 4'h0, 4'hF, 0, 0, 0, 0, 0));
    // W alone is blocked until an AW goes out
    vecs.push_back(v(0, 4'h2, 4'hD, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'h2, 4'hD, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 4'h3, 4'hF, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'h2, 4'hF, 1, 1, 1, 1, 0));
    vecs.push_back(v(0, 4'h0, 4'hF, 1, 0, 0, 0, 0));
    // 4-beat locked W burst with a stall, ch2/ch3 competing
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'hE, 4'hD, 1, 1, 1, 1, 0));
    vecs.push_back(v(0, 4'hE, 4'hD, 0, 1, 1, 1, 1));
    vecs.push_back(v(0, 4'hE, 4'hD, 1, 1, 1, 1, 1));
    vecs.push_back(v(0, 4'hE, 4'hD, 1, 1, 1, 1, 1));
    vecs.push_back(v(0, 4'hE, 4'hF, 1, 1, 1, 1, 1));
    vecs.push_back(v(0, 4'hC, 4'hF, 1, 1, 2, 0, 0));
    vecs.push_back(v(0, 4'h0, 4'hF, 1, 0, 0, 0, 0));
    // Outstanding-AW limit
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 0, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 1, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 2, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 3, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 0, 0, 4, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 0, 0, 4, 0));
    vecs.push_back(v(0, 4'h3, 4'hF, 1, 1, 1, 4, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 1, 0, 3, 0));
    vecs.push_back(v(0, 4'h1, 4'hF, 1, 0, 0, 4, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].last, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ech, vecs[i].eaw,
                 vecs[i].elk, vecs[i].rdy);
    end

    // Backpressure: ch3 held while ch0 rises; ch0 must wait for ch3 to be accepted
    drive(1, 4'h0, 4'hF, 0);
    expect_out("bp_rst", 0, 0, 0, 0, 0);
    drive(0, 4'h8, 4'hF, 0);
    expect_out("bp_c0", 1, 3, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 4'h9, 4'hF, 0);
      expect_out($sformatf("bp_c%0d", i), 1, 3, 0, 0, 0);
    end
    drive(0, 4'h9, 4'hF, 1);
    expect_out("bp_acc3", 1, 3, 0, 0, 1);
    drive(0, 4'h1, 4'hF, 1);
    expect_out("bp_acc0", 1, 0, 0, 0, 1);
    // Idle ready must not move the pointer
    drive(0, 4'h0, 4'hF, 1);
    expect_out("idle0", 0, 0, 1, 0, 1);
    drive(0, 4'h0, 4'hF, 1);
    expect_out("idle1", 0, 0, 1, 0, 1);
    drive(0, 4'hC, 4'hF, 1);
    expect_out("idle_rr", 1, 2, 1, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
